// File: rtl/rf_write_arbiter.sv
// +--------------------------------------------------------------------------+
// | rf_write_arbiter: merges ALU and queued MDU writebacks onto one regfile   |
// | write port and exports a pending-write mask.  Rev 1.0                     |
// +--------------------------------------------------------------------------+
`default_nettype none

module rf_write_arbiter #(
  parameter int DWIDTH     = 32,
  parameter int FIFO_DEPTH = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              alu_valid,
  input  logic [4:0]        alu_addr,
  input  logic [DWIDTH-1:0] alu_data,
  input  logic              mdu_valid,
  output logic              mdu_ready,
  input  logic [4:0]        mdu_addr,
  input  logic [DWIDTH-1:0] mdu_data,
  output logic              wr,
  output logic [4:0]        wraddr,
  output logic [DWIDTH-1:0] din,
  output logic [31:0]       pending
);

  localparam int              c_pw   = $clog2(FIFO_DEPTH);
  localparam int              c_cw   = c_pw + 1;
  localparam logic [c_cw-1:0] c_full = c_cw'(FIFO_DEPTH);

  logic [4:0]        addr_q [FIFO_DEPTH];
  logic [4:0]        addr_d [FIFO_DEPTH];
  logic [DWIDTH-1:0] data_q [FIFO_DEPTH];
  logic [DWIDTH-1:0] data_d [FIFO_DEPTH];
  logic [FIFO_DEPTH-1:0] live_q, live_d;
  logic [c_pw-1:0]   wptr_q, wptr_d, rptr_q, rptr_d;
  logic [c_cw-1:0]   count_q, count_d;
  logic              wr_q, wr_d;
  logic [4:0]        wraddr_q, wraddr_d;
  logic [DWIDTH-1:0] din_q, din_d;
  logic [31:0]       pending_q, pending_d;

  logic w_alu_issue;
  logic w_push;
  logic w_enq;
  logic w_pop;

  assign mdu_ready   = (count_q != c_full);
  assign w_alu_issue = alu_valid && (alu_addr != 5'd0);
  assign w_push      = mdu_valid && mdu_ready;
  // r0 handshakes are accepted but never occupy a slot.
  assign w_enq       = w_push && (mdu_addr != 5'd0);
  assign w_pop       = !w_alu_issue && (count_q != '0);

  always_comb begin
    addr_d    = addr_q;
    data_d    = data_q;
    live_d    = live_q;
    wptr_d    = wptr_q;
    rptr_d    = rptr_q;
    count_d   = count_q;
    wr_d      = 1'b0;
    wraddr_d  = wraddr_q;
    din_d     = din_q;
    pending_d = '0;

    if (w_alu_issue) begin
      wr_d     = 1'b1;
      wraddr_d = alu_addr;
      din_d    = alu_data;
      // Squash older queued writes to the same register; a same-cycle push is
      // applied afterwards so it stays live as the younger write.
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        if (live_q[i] && (addr_q[i] == alu_addr)) begin
          live_d[i] = 1'b0;
        end
      end
    end else if (w_pop) begin
      wr_d = live_q[rptr_q];
      if (live_q[rptr_q]) begin
        wraddr_d = addr_q[rptr_q];
        din_d    = data_q[rptr_q];
      end
      live_d[rptr_q] = 1'b0;
      rptr_d         = rptr_q + c_pw'(1);
    end

    if (w_enq) begin
      addr_d[wptr_q] = mdu_addr;
      data_d[wptr_q] = mdu_data;
      live_d[wptr_q] = 1'b1;
      wptr_d         = wptr_q + c_pw'(1);
    end

    case ({w_enq, w_pop})
      2'b10:   count_d = count_q + c_cw'(1);
      2'b01:   count_d = count_q - c_cw'(1);
      default: count_d = count_q;
    endcase

    for (int i = 0; i < FIFO_DEPTH; i++) begin
      if (live_d[i]) begin
        pending_d = pending_d | (32'(1) << addr_d[i]);
      end
    end
    pending_d[0] = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        addr_q[i] <= '0;
        data_q[i] <= '0;
      end
      live_q    <= '0;
      wptr_q    <= '0;
      rptr_q    <= '0;
      count_q   <= '0;
      wr_q      <= 1'b0;
      wraddr_q  <= '0;
      din_q     <= '0;
      pending_q <= '0;
    end else begin
      addr_q    <= addr_d;
      data_q    <= data_d;
      live_q    <= live_d;
      wptr_q    <= wptr_d;
      rptr_q    <= rptr_d;
      count_q   <= count_d;
      wr_q      <= wr_d;
      wraddr_q  <= wraddr_d;
      din_q     <= din_d;
      pending_q <= pending_d;
    end
  end

  assign wr      = wr_q;
  assign wraddr  = wraddr_q;
  assign din     = din_q;
  assign pending = pending_q;

endmodule

`default_nettype wire

// File: tb/tb_rf_write_arbiter.sv
// +--------------------------------------------------------------------------+
// | tb_rf_write_arbiter: directed self-checking bench for rf_write_arbiter.   |
// | Rev 1.0                                                                   |
// +--------------------------------------------------------------------------+
`default_nettype none

module tb_rf_write_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        alu_valid;
  logic [4:0]  alu_addr;
  logic [31:0] alu_data;
  logic        mdu_valid;
  logic        mdu_ready;
  logic [4:0]  mdu_addr;
  logic [31:0] mdu_data;
  logic        wr;
  logic [4:0]  wraddr;
  logic [31:0] din;
  logic [31:0] pending;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  rf_write_arbiter #(.DWIDTH(32), .FIFO_DEPTH(2)) dut (
    .clk       (clk),
    .rst       (rst),
    .alu_valid (alu_valid),
    .alu_addr  (alu_addr),
    .alu_data  (alu_data),
    .mdu_valid (mdu_valid),
    .mdu_ready (mdu_ready),
    .mdu_addr  (mdu_addr),
    .mdu_data  (mdu_data),
    .wr        (wr),
    .wraddr    (wraddr),
    .din       (din),
    .pending   (pending)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Advance one edge and settle before sampling.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_alu(input logic v, input logic [4:0] a, input logic [31:0] d);
    alu_valid = v;
    alu_addr  = a;
    alu_data  = d;
  endtask

  task automatic set_mdu(input logic v, input logic [4:0] a, input logic [31:0] d);
    mdu_valid = v;
    mdu_addr  = a;
    mdu_data  = d;
  endtask

  initial begin
    rst = 1'b1;
    set_alu(1'b1, 5'd5, 32'hDEAD_BEEF);
    set_mdu(1'b0, 5'd0, 32'h0);

    // Reset held two cycles with ALU traffic present
    step();
    step();
    check("rst_wr",      {31'b0, wr}, 32'd0);
    check("rst_wraddr",  {27'b0, wraddr}, 32'd0);
    check("rst_din",     din, 32'd0);
    check("rst_pending", pending, 32'd0);
    check("rst_ready",   {31'b0, mdu_ready}, 32'd1);
    rst = 1'b0;

    // ALU only
    set_alu(1'b1, 5'd5, 32'hA5A5_A5A5);
    step();
    check("alu_wr",     {31'b0, wr}, 32'd1);
    check("alu_wraddr", {27'b0, wraddr}, 32'd5);
    check("alu_din",    din, 32'hA5A5_A5A5);
    set_alu(1'b1, 5'd0, 32'h1234_5678);
    step();
    check("alu_r0_wr",   {31'b0, wr}, 32'd0);
    check("alu_r0_hold", {27'b0, wraddr}, 32'd5);
    check("alu_r0_din",  din, 32'hA5A5_A5A5);

    // MDU handshake to r0 is accepted but not queued
    set_alu(1'b0, 5'd0, 32'h0);
    set_mdu(1'b1, 5'd0, 32'h5555_5555);
    step();
    check("mdu_r0_pending", pending, 32'd0);
    check("mdu_r0_ready",   {31'b0, mdu_ready}, 32'd1);
    set_mdu(1'b0, 5'd0, 32'h0);
    step();
    check("mdu_r0_wr", {31'b0, wr}, 32'd0);

    // Backpressure: ALU holds the port while two MDU results queue
    set_alu(1'b1, 5'd1, 32'h0000_00C1);
    set_mdu(1'b1, 5'd3, 32'd1);
    step();
    check("bp_pend1",  pending, 32'h0000_0008);
    check("bp_ready1", {31'b0, mdu_ready}, 32'd1);
    set_mdu(1'b1, 5'd4, 32'd2);
    step();
    check("bp_pend2",  pending, 32'h0000_0018);
    check("bp_ready2", {31'b0, mdu_ready}, 32'd0);
    set_mdu(1'b1, 5'd12, 32'hFFFF_FFFF);
    step();
    check("bp_alu_wr",     {31'b0, wr}, 32'd1);
    check("bp_alu_wraddr", {27'b0, wraddr}, 32'd1);
    check("bp_full_pend",  pending, 32'h0000_0018);
    check("bp_full_ready", {31'b0, mdu_ready}, 32'd0);
    set_alu(1'b0, 5'd0, 32'h0);
    set_mdu(1'b0, 5'd0, 32'h0);
    step();
    check("bp_d1_wr",     {31'b0, wr}, 32'd1);
    check("bp_d1_wraddr", {27'b0, wraddr}, 32'd3);
    check("bp_d1_din",    din, 32'd1);
    check("bp_d1_pend",   pending, 32'h0000_0010);
    check("bp_d1_ready",  {31'b0, mdu_ready}, 32'd1);
    step();
    check("bp_d2_wr",     {31'b0, wr}, 32'd1);
    check("bp_d2_wraddr", {27'b0, wraddr}, 32'd4);
    check("bp_d2_din",    din, 32'd2);
    check("bp_d2_pend",   pending, 32'd0);
    step();
    check("bp_idle_wr", {31'b0, wr}, 32'd0);

    // WAW squash
    set_mdu(1'b1, 5'd7, 32'h11);
    step();
    check("waw_q_wr",   {31'b0, wr}, 32'd0);
    check("waw_q_pend", pending, 32'h0000_0080);
    set_mdu(1'b0, 5'd0, 32'h0);
    set_alu(1'b1, 5'd7, 32'h22);
    step();
    check("waw_alu_wr",     {31'b0, wr}, 32'd1);
    check("waw_alu_wraddr", {27'b0, wraddr}, 32'd7);
    check("waw_alu_din",    din, 32'h22);
    check("waw_alu_pend",   pending, 32'd0);
    set_alu(1'b0, 5'd0, 32'h0);
    step();
    check("waw_sq_wr",    {31'b0, wr}, 32'd0);
    check("waw_sq_din",   din, 32'h22);
    check("waw_sq_ready", {31'b0, mdu_ready}, 32'd1);
    step();
    check("waw_idle_wr", {31'b0, wr}, 32'd0);

    // Same-cycle ALU write and MDU push to r9
    set_alu(1'b1, 5'd9, 32'h1);
    set_mdu(1'b1, 5'd9, 32'h2);
    step();
    check("same_alu_wr",     {31'b0, wr}, 32'd1);
    check("same_alu_wraddr", {27'b0, wraddr}, 32'd9);
    check("same_alu_din",    din, 32'h1);
    check("same_pend",       pending, 32'h0000_0200);
    set_alu(1'b0, 5'd0, 32'h0);
    set_mdu(1'b0, 5'd0, 32'h0);
    step();
    check("same_mdu_wr",     {31'b0, wr}, 32'd1);
    check("same_mdu_wraddr", {27'b0, wraddr}, 32'd9);
    check("same_mdu_din",    din, 32'h2);
    check("same_mdu_pend",   pending, 32'd0);

    // Reset mid-drain
    set_alu(1'b1, 5'd1, 32'h0);
    set_mdu(1'b1, 5'd10, 32'h33);
    step();
    set_mdu(1'b1, 5'd11, 32'h44);
    step();
    check("rmd_pend", pending, 32'h0000_0C00);
    rst = 1'b1;
    set_alu(1'b0, 5'd0, 32'h0);
    set_mdu(1'b0, 5'd0, 32'h0);
    step();
    check("rmd_rst_wr",    {31'b0, wr}, 32'd0);
    check("rmd_rst_pend",  pending, 32'd0);
    check("rmd_rst_ready", {31'b0, mdu_ready}, 32'd1);
    rst = 1'b0;
    step();
    check("rmd_after1_wr", {31'b0, wr}, 32'd0);
    step();
    check("rmd_after2_wr", {31'b0, wr}, 32'd0);
    check("rmd_after2_pend", pending, 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
